// File: rtl/spike_rate_encoder_if.sv
// Handshake and spike bus between the host/sensor side and the rate encoder.
// The host drives in_valid/in_value; the encoder drives the rest.
interface spike_rate_encoder_if #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned VAL_W    = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*VAL_W-1:0] in_value;
    logic [CHANNELS-1:0]       spike_out;
    logic                      busy;
    logic                      frame_done;

    modport master (
        output in_valid,
        output in_value,
        input  in_ready,
        input  spike_out,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  in_valid,
        input  in_value,
        output in_ready,
        output spike_out,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/spike_rate_encoder.sv
// Accumulator-based rate coder: each accepted value set yields WINDOW spike ticks per channel.
// Optional SPIKE_ENC_REFRACT_EN adds a 1-tick refractory period per channel.
module spike_rate_encoder #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned VAL_W    = 8,
    parameter int unsigned WINDOW   = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    spike_rate_encoder_if.slave  io_bus
);
    localparam int unsigned       TICK_W    = $clog2(WINDOW);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(WINDOW - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                         r_state, w_state_nxt;
    logic [TICK_W-1:0]              r_tick, w_tick_nxt;
    logic [CHANNELS-1:0][VAL_W-1:0] r_val, w_val_nxt;
    logic [CHANNELS-1:0][VAL_W-1:0] r_acc, w_acc_nxt;
    logic [CHANNELS-1:0]            r_spike, w_spike_nxt;
    logic                           r_done, w_done_nxt;
    logic                           r_ready, w_ready_nxt;
    logic                           w_accept;
`ifdef SPIKE_ENC_REFRACT_EN
    logic [CHANNELS-1:0]            r_refr, w_refr_nxt;
`endif

    // r_ready always equals the IDLE / last-tick decode of the current state
    assign w_accept = io_bus.in_valid & r_ready;

    // State, tick and per-channel datapath registers
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_val   <= '0;
            r_acc   <= '0;
            r_spike <= '0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
`ifdef SPIKE_ENC_REFRACT_EN
            r_refr  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_val   <= w_val_nxt;
            r_acc   <= w_acc_nxt;
            r_spike <= w_spike_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
`ifdef SPIKE_ENC_REFRACT_EN
            r_refr  <= w_refr_nxt;
`endif
        end
    end

    // Next-state, accumulation and spike generation
    always_comb begin
        logic [VAL_W:0] w_sum;
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_val_nxt   = r_val;
        w_acc_nxt   = r_acc;
        w_spike_nxt = '0;
        w_done_nxt  = 1'b0;
        w_sum       = '0;
`ifdef SPIKE_ENC_REFRACT_EN
        w_refr_nxt  = r_refr;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                    w_tick_nxt  = '0;
                    w_val_nxt   = io_bus.in_value;
                    w_acc_nxt   = '0;
`ifdef SPIKE_ENC_REFRACT_EN
                    w_refr_nxt  = '0;
`endif
                end
            end
            S_RUN: begin
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    w_sum        = {1'b0, r_acc[i]} + {1'b0, r_val[i]};
                    w_acc_nxt[i] = w_sum[VAL_W-1:0];
`ifdef SPIKE_ENC_REFRACT_EN
                    w_spike_nxt[i] = w_sum[VAL_W] & ~r_refr[i];
                    w_refr_nxt[i]  = w_sum[VAL_W] & ~r_refr[i];
`else
                    w_spike_nxt[i] = w_sum[VAL_W];
`endif
                end
                w_tick_nxt = r_tick + TICK_W'(1);
                if (r_tick == LAST_TICK) begin
                    // Spikes on this edge still belong to the finishing frame
                    w_done_nxt = 1'b1;
                    w_tick_nxt = '0;
                    if (w_accept) begin
                        w_val_nxt  = io_bus.in_value;
                        w_acc_nxt  = '0;
`ifdef SPIKE_ENC_REFRACT_EN
                        w_refr_nxt = '0;
`endif
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_ready_nxt = (w_state_nxt == S_IDLE) || (w_tick_nxt == LAST_TICK);
    end

    assign io_bus.in_ready   = r_ready;
    assign io_bus.spike_out  = r_spike;
    assign io_bus.busy       = (r_state == S_RUN);
    assign io_bus.frame_done = r_done;
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: idle, single frames, back-to-back frames,
// mid-frame reset and ignored offers while running.
module tb_spike_rate_encoder;
    localparam int unsigned CHANNELS = 3;
    localparam int unsigned VAL_W    = 8;
    localparam int unsigned WINDOW   = 16;

    logic clk = 1'b0;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;

    spike_rate_encoder_if #(.CHANNELS(CHANNELS), .VAL_W(VAL_W)) bus ();

    spike_rate_encoder #(
        .CHANNELS (CHANNELS),
        .VAL_W    (VAL_W),
        .WINDOW   (WINDOW)
    ) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one value set, record spikes after E1..E16 as bit k of each mask
    task automatic run_frame(input string tag, input logic [23:0] vals,
                             input logic [63:0] e0, input logic [63:0] e1,
                             input logic [63:0] e2);
        logic [63:0] m0, m1, m2;
        int          done_cnt;
        m0 = '0; m1 = '0; m2 = '0; done_cnt = 0;
        bus.in_valid = 1'b1;
        bus.in_value = vals;
        step();
        bus.in_valid = 1'b0;
        bus.in_value = 24'hA5A5A5;
        check_eq({tag, " ready after accept"}, 64'(bus.in_ready), 64'd0);
        for (int k = 1; k <= 17; k++) begin
            step();
            m0[k] = bus.spike_out[0];
            m1[k] = bus.spike_out[1];
            m2[k] = bus.spike_out[2];
            done_cnt += int'(bus.frame_done);
            if (k == 15) begin
                check_eq({tag, " ready at last tick"}, 64'(bus.in_ready), 64'd1);
                check_eq({tag, " busy mid frame"}, 64'(bus.busy), 64'd1);
            end
            if (k == 16) begin
                check_eq({tag, " done after E16"}, 64'(bus.frame_done), 64'd1);
                check_eq({tag, " busy after E16"}, 64'(bus.busy), 64'd0);
            end
        end
        check_eq({tag, " ch0 spikes"}, m0, e0);
        check_eq({tag, " ch1 spikes"}, m1, e1);
        check_eq({tag, " ch2 spikes"}, m2, e2);
        check_eq({tag, " done count"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        logic        any_spike, any_busy, any_done, all_ready;
        logic [63:0] m0, m2;
        int          done_cnt;
        logic        busy_all;
        logic [63:0] exp_full;

`ifdef SPIKE_ENC_REFRACT_EN
        exp_full = 64'h1_5554;
`else
        exp_full = 64'h1_FFFC;
`endif
        resetn       = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        repeat (3) step();
        check_eq("reset spike", 64'(bus.spike_out), 64'd0);
        check_eq("reset busy", 64'(bus.busy), 64'd0);
        check_eq("reset done", 64'(bus.frame_done), 64'd0);
        resetn = 1'b0;
        step();
        check_eq("ready after reset", 64'(bus.in_ready), 64'd1);

        // Idle with no offers
        any_spike = 1'b0; any_busy = 1'b0; any_done = 1'b0; all_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            any_spike |= |bus.spike_out;
            any_busy  |= bus.busy;
            any_done  |= bus.frame_done;
            all_ready &= bus.in_ready;
        end
        check_eq("idle spikes", 64'(any_spike), 64'd0);
        check_eq("idle busy", 64'(any_busy), 64'd0);
        check_eq("idle done", 64'(any_done), 64'd0);
        check_eq("idle ready", 64'(all_ready), 64'd1);

        run_frame("vals 0/64/128", {8'd128, 8'd64, 8'd0}, 64'h0, 64'h1_1110, 64'h1_5554);
        run_frame("vals 255/1/255", {8'd255, 8'd1, 8'd255}, exp_full, 64'h0, exp_full);

        // Back-to-back: 128s then 64s with in_valid held high
        bus.in_valid = 1'b1;
        bus.in_value = {3{8'd128}};
        step();
        check_eq("b2b ready in run", 64'(bus.in_ready), 64'd0);
        bus.in_value = {3{8'd64}};
        m0 = '0; m2 = '0; done_cnt = 0; busy_all = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            step();
            m0[k] = bus.spike_out[0];
            m2[k] = bus.spike_out[2];
            done_cnt += int'(bus.frame_done);
            if (k <= 31) busy_all &= bus.busy;
            if (k == 16) begin
                check_eq("b2b done E16", 64'(bus.frame_done), 64'd1);
                bus.in_valid = 1'b0;
            end
        end
        check_eq("b2b ch0 spikes", m0, 64'h1_1111_5554);
        check_eq("b2b ch2 spikes", m2, 64'h1_1111_5554);
        check_eq("b2b done count", 64'(done_cnt), 64'd2);
        check_eq("b2b busy held", 64'(busy_all), 64'd1);
        check_eq("b2b idle after", 64'(bus.busy), 64'd0);

        // Reset at E5 of a 128 frame, then a fresh frame
        bus.in_valid = 1'b1;
        bus.in_value = {3{8'd128}};
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        resetn = 1'b1;
        step();
        check_eq("midrst busy", 64'(bus.busy), 64'd0);
        check_eq("midrst spike", 64'(bus.spike_out), 64'd0);
        check_eq("midrst done", 64'(bus.frame_done), 64'd0);
        check_eq("midrst ready", 64'(bus.in_ready), 64'd1);
        resetn = 1'b0;
        run_frame("after reset 128", {3{8'd128}}, 64'h1_5554, 64'h1_5554, 64'h1_5554);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
